// File: rtl/smvm_frame_tx.sv
// smvm_frame_tx: streams a header, vector and padded nonzero list to the
// SMVM accelerator byte port, buffering upstream words in a small FIFO so a
// started frame is emitted without gaps, then holds an idle recovery gap.
module smvm_frame_tx #(
  parameter int unsigned K     = 4,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned GAP   = 7,
  parameter int unsigned NNZ_W = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [8:0]       rows,
  input  logic [8:0]       cols,
  input  logic [NNZ_W-1:0] nnz,
  output logic             busy,
  output logic             done,
  output logic             err,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [17:0]      s_data,
  output logic             tx_valid,
  output logic [7:0]       tx_val,
  output logic             tx_ipv
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam int unsigned WW = NNZ_W + 1;
  localparam int unsigned PW = $clog2(K) + 1;

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_PREFILL = 4'd1;
  localparam logic [3:0] S_HDR_R   = 4'd2;
  localparam logic [3:0] S_HDR_C   = 4'd3;
  localparam logic [3:0] S_VEC     = 4'd4;
  localparam logic [3:0] S_NZ_V    = 4'd5;
  localparam logic [3:0] S_NZ_I    = 4'd6;
  localparam logic [3:0] S_PD_V    = 4'd7;
  localparam logic [3:0] S_PD_I    = 4'd8;
  localparam logic [3:0] S_GAP     = 4'd9;

  logic [3:0]       r_state, w_state_nxt;
  logic [8:0]       r_rows, r_cols;
  logic [NNZ_W-1:0] r_nnz, r_idx, w_idx_nxt;
  logic [PW-1:0]    r_pad, w_pad_in;
  logic [WW-1:0]    r_w, r_acc, w_w_nxt, w_acc_nxt, w_need;
  logic [17:0]      r_mem [DEPTH];
  logic [AW-1:0]    r_wptr, r_rptr;
  logic [CW-1:0]    r_fcnt, w_fcnt_nxt;
  logic [17:0]      w_head;
  logic             w_push, w_pop, w_clr, w_latch, w_empty;
  logic             w_want_vec, w_want_nzv, w_want_end;
  logic             w_tx_valid, w_tx_ipv, w_done, w_err, w_busy, w_s_ready;
  logic [7:0]       w_tx_val;
  logic             r_tx_valid, r_tx_ipv, r_done, r_err, r_busy, r_s_ready;
  logic [7:0]       r_tx_val;

  assign tx_valid = r_tx_valid;
  assign tx_val   = r_tx_val;
  assign tx_ipv   = r_tx_ipv;
  assign done     = r_done;
  assign err      = r_err;
  assign busy     = r_busy;
  assign s_ready  = r_s_ready;

  assign w_push   = s_valid && r_s_ready;
  assign w_empty  = (r_fcnt == '0);
  assign w_head   = r_mem[r_rptr];
  assign w_need   = (r_w < WW'(DEPTH)) ? r_w : WW'(DEPTH);
  assign w_pad_in = PW'((K - (32'(nnz) % K)) % K);

  // Next state and the byte to present on the port during that state
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_tx_valid  = 1'b0;
    w_tx_val    = '0;
    w_tx_ipv    = 1'b0;
    w_pop       = 1'b0;
    w_clr       = 1'b0;
    w_latch     = 1'b0;
    w_done      = 1'b0;
    w_err       = 1'b0;
    w_want_vec  = 1'b0;
    w_want_nzv  = 1'b0;
    w_want_end  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_latch     = 1'b1;
          w_idx_nxt   = '0;
          w_state_nxt = S_PREFILL;
        end
      end
      S_PREFILL: begin
        if (WW'(r_fcnt) >= w_need) begin
          w_state_nxt = S_HDR_R;
          w_tx_valid  = 1'b1;
          w_tx_val    = r_rows[8:1];
          w_tx_ipv    = r_rows[0];
        end
      end
      S_HDR_R: begin
        w_state_nxt = S_HDR_C;
        w_tx_valid  = 1'b1;
        w_tx_val    = r_cols[8:1];
        w_tx_ipv    = r_cols[0];
        w_idx_nxt   = '0;
      end
      S_HDR_C: begin
        if (r_cols != '0)      w_want_vec = 1'b1;
        else if (r_nnz != '0)  w_want_nzv = 1'b1;
        else                   w_want_end = 1'b1;
      end
      S_VEC: begin
        if (r_idx < NNZ_W'(r_cols)) begin
          w_want_vec = 1'b1;
        end else begin
          w_idx_nxt = '0;
          if (r_nnz != '0) w_want_nzv = 1'b1;
          else             w_want_end = 1'b1;
        end
      end
      S_NZ_V: begin
        w_state_nxt = S_NZ_I;
        w_tx_valid  = 1'b1;
        w_tx_val    = w_head[16:9];
        w_tx_ipv    = w_head[8];
        w_pop       = 1'b1;
        w_idx_nxt   = r_idx + NNZ_W'(1);
      end
      S_NZ_I: begin
        if (r_idx < r_nnz) begin
          w_want_nzv = 1'b1;
        end else if (r_pad != '0) begin
          w_state_nxt = S_PD_V;
          w_tx_valid  = 1'b1;
          w_idx_nxt   = '0;
        end else begin
          w_want_end = 1'b1;
        end
      end
      S_PD_V: begin
        w_state_nxt = S_PD_I;
        w_tx_valid  = 1'b1;
        w_idx_nxt   = r_idx + NNZ_W'(1);
      end
      S_PD_I: begin
        if (r_idx < NNZ_W'(r_pad)) begin
          w_state_nxt = S_PD_V;
          w_tx_valid  = 1'b1;
        end else begin
          w_want_end = 1'b1;
        end
      end
      S_GAP: begin
        if (r_idx == NNZ_W'(GAP - 1)) begin
          w_state_nxt = S_IDLE;
          w_idx_nxt   = '0;
        end else begin
          w_idx_nxt   = r_idx + NNZ_W'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // A data state with nothing buffered aborts the frame (underrun)
    if (w_want_vec || w_want_nzv) begin
      if (w_empty) begin
        w_state_nxt = S_GAP;
        w_err       = 1'b1;
        w_clr       = 1'b1;
        w_idx_nxt   = '0;
      end else begin
        w_tx_valid = 1'b1;
        w_tx_val   = w_head[7:0];
        w_tx_ipv   = w_want_nzv ? w_head[17] : 1'b0;
        if (w_want_vec) begin
          w_state_nxt = S_VEC;
          w_pop       = 1'b1;
          w_idx_nxt   = r_idx + NNZ_W'(1);
        end else begin
          w_state_nxt = S_NZ_V;
        end
      end
    end
    if (w_want_end) begin
      w_state_nxt = S_GAP;
      w_done      = 1'b1;
      w_idx_nxt   = '0;
    end
  end

  // FIFO occupancy, word budget and upstream ready for the next cycle
  always_comb begin
    w_fcnt_nxt = w_clr ? '0 : (r_fcnt + CW'(w_push) - CW'(w_pop));
    w_w_nxt    = w_latch ? (WW'(cols) + WW'(nnz)) : r_w;
    w_acc_nxt  = (w_clr || w_latch) ? '0 : (r_acc + WW'(w_push));
    w_busy     = (w_state_nxt != S_IDLE);
    w_s_ready  = w_busy && (w_state_nxt != S_GAP) &&
                 (w_fcnt_nxt < CW'(DEPTH)) && (w_acc_nxt < w_w_nxt);
  end

  // FIFO storage, no reset needed since reads are gated by occupancy
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= s_data;
  end

  // State, frame parameters, FIFO pointers and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_rows     <= '0;
      r_cols     <= '0;
      r_nnz      <= '0;
      r_pad      <= '0;
      r_w        <= '0;
      r_acc      <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_fcnt     <= '0;
      r_tx_valid <= 1'b0;
      r_tx_val   <= '0;
      r_tx_ipv   <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_busy     <= 1'b0;
      r_s_ready  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      if (w_latch) begin
        r_rows <= rows;
        r_cols <= cols;
        r_nnz  <= nnz;
        r_pad  <= w_pad_in;
      end
      r_w    <= w_w_nxt;
      r_acc  <= w_acc_nxt;
      r_fcnt <= w_fcnt_nxt;
      if (w_clr) begin
        r_wptr <= '0;
        r_rptr <= '0;
      end else begin
        if (w_push) r_wptr <= r_wptr + AW'(1);
        if (w_pop)  r_rptr <= r_rptr + AW'(1);
      end
      r_tx_valid <= w_tx_valid;
      r_tx_val   <= w_tx_val;
      r_tx_ipv   <= w_tx_ipv;
      r_done     <= w_done;
      r_err      <= w_err;
      r_busy     <= w_busy;
      r_s_ready  <= w_s_ready;
    end
  end

endmodule

// File: tb/tb_smvm_frame_tx.sv
// Bench for smvm_frame_tx: a reference model expands each frame request into
// the expected byte stream; a monitor pops and compares every tx_valid beat.
module tb_smvm_frame_tx;
  localparam int unsigned K     = 4;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned GAP   = 7;
  localparam int unsigned NNZ_W = 12;

  logic             clk, rst_n, start;
  logic [8:0]       rows, cols;
  logic [NNZ_W-1:0] nnz;
  logic             busy, done, err, s_valid, s_ready, tx_valid, tx_ipv;
  logic [17:0]      s_data;
  logic [7:0]       tx_val;

  smvm_frame_tx #(.K(K), .DEPTH(DEPTH), .GAP(GAP), .NNZ_W(NNZ_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rows(rows), .cols(cols),
    .nnz(nnz), .busy(busy), .done(done), .err(err), .s_valid(s_valid),
    .s_ready(s_ready), .s_data(s_data), .tx_valid(tx_valid),
    .tx_val(tx_val), .tx_ipv(tx_ipv)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [17:0] up_q [$];
  logic [8:0]  exp_q [$];
  int n_valid, n_runs, n_done, n_err, first_tx;
  logic prev_tx = 1'b0;
  int acc_cnt = 0, stall_after = -1, stall_len = 30, stall_rem = 0;
  logic hs_d;

  function automatic void chk(input string nm, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", nm, act, exp_v, $time);
    end
  endfunction

  always @(posedge clk) cyc++;

  // Monitor: every emitted beat must match the head of the expected stream
  always @(negedge clk) begin
    if (rst_n) begin
      if (tx_valid) begin
        if (!prev_tx) begin
          n_runs++;
          if (first_tx < 0) first_tx = cyc;
        end
        n_valid++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL tx_unexpected actual=%0d expected=none", {tx_val, tx_ipv});
        end else begin
          logic [8:0] e;
          e = exp_q.pop_front();
          chk("tx_byte", int'({tx_val, tx_ipv}), int'(e));
        end
      end
      if (done) n_done++;
      if (err)  n_err++;
      prev_tx = tx_valid;
    end else begin
      prev_tx = 1'b0;
    end
  end

  // Upstream driver: offers queued words, optionally stalls after N accepts
  initial begin
    logic [17:0] wd;
    s_valid = 1'b0;
    s_data  = '0;
    forever begin
      @(negedge clk);
      hs_d = s_valid && s_ready && rst_n;
      @(posedge clk);
      #1;
      if (stall_rem > 0) stall_rem--;
      if (hs_d && rst_n && up_q.size() > 0) begin
        wd = up_q.pop_front();
        acc_cnt++;
        if (acc_cnt == stall_after) stall_rem = stall_len;
      end
      s_valid = (up_q.size() > 0) && (stall_rem == 0);
      s_data  = (up_q.size() > 0) ? up_q[0] : 18'h0;
    end
  end

  // Reference model: builds upstream words and the expected byte stream
  task automatic load_frame(input int r, input int c, input int n,
                            input int stop_at, input bit expect_err, input int force_col);
    logic [17:0] wd;
    logic [8:0]  f;
    int p;
    up_q.delete();
    exp_q.delete();
    n_valid = 0; n_runs = 0; n_done = 0; n_err = 0; first_tx = -1;
    acc_cnt = 0; stall_after = stop_at; stall_rem = 0;
    p = (K - (n % K)) % K;
    f = 9'(r); exp_q.push_back(f);
    f = 9'(c); exp_q.push_back(f);
    for (int i = 0; i < c; i++) begin
      wd = 18'($urandom);
      up_q.push_back(wd);
      if (!expect_err || i < stop_at) exp_q.push_back({wd[7:0], 1'b0});
    end
    for (int i = 0; i < n; i++) begin
      wd = 18'($urandom);
      if (i == 0 && force_col >= 0) wd[16:8] = 9'(force_col);
      up_q.push_back(wd);
      if (!expect_err) begin
        exp_q.push_back({wd[7:0], wd[17]});
        exp_q.push_back(wd[16:8]);
      end
    end
    if (!expect_err) begin
      for (int i = 0; i < p; i++) begin
        exp_q.push_back(9'h0);
        exp_q.push_back(9'h0);
      end
      for (int i = 0; i < 3; i++) up_q.push_back(18'($urandom));
    end
  endtask

  task automatic issue_start(input int r, input int c, input int n, output int c0);
    @(negedge clk);
    rows = 9'(r); cols = 9'(c); nnz = NNZ_W'(n); start = 1'b1;
    c0 = cyc;
    @(negedge clk);
    start = 1'b0;
    rows = 9'($urandom); cols = 9'($urandom); nnz = NNZ_W'($urandom);
  endtask

  task automatic run_frame(input int r, input int c, input int n, input int stop_at,
                           input bit expect_err, input bit extra_start, input int force_col);
    int c0, t, bad, p, w, m;
    load_frame(r, c, n, stop_at, expect_err, force_col);
    p = (K - (n % K)) % K;
    w = c + n;
    m = (w < int'(DEPTH)) ? w : int'(DEPTH);
    issue_start(r, c, n, c0);
    t = 0;
    while (!(done || err) && t < 4000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 4000) begin
      checks++;
      failures++;
      $display("FAIL frame_timeout actual=no_end expected=done_or_err");
    end else begin
      if (expect_err) chk("underrun_tx_valid", int'(tx_valid), 0);
      bad = 0;
      for (int k = 0; k < int'(GAP); k++) begin
        if (k > 0) @(negedge clk);
        if (!busy || s_ready) bad++;
        if (k == 1 && extra_start) begin
          start = 1'b1;
          rows = 9'($urandom_range(511, 1)); cols = 9'($urandom); nnz = NNZ_W'($urandom);
        end else begin
          start = 1'b0;
        end
      end
      chk("gap_busy_sready", bad, 0);
      @(negedge clk);
      start = 1'b0;
      chk("busy_fall", int'(busy), 0);
    end
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (busy || tx_valid) bad++;
    end
    chk("idle_after_frame", bad, 0);
    chk("exp_drained", exp_q.size(), 0);
    chk("done_count", n_done, expect_err ? 0 : 1);
    chk("err_count", n_err, expect_err ? 1 : 0);
    chk("tx_runs", n_runs, 1);
    chk("frame_len", n_valid, expect_err ? 2 + stop_at : 2 + c + 2 * (n + p));
    chk("accepted", acc_cnt, expect_err ? stop_at : w);
    chk("first_tx_latency", first_tx - c0, 2 + m);
    up_q.delete();
  endtask

  initial begin
    int t, c0;
    rst_n = 1'b0; start = 1'b0; rows = '0; cols = '0; nnz = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", int'({tx_valid, tx_val, tx_ipv, s_ready, busy, done, err}), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_frame(3, 4, 4, -1, 1'b0, 1'b0, -1);
    run_frame(int'($urandom_range(511, 1)), 2, 5, -1, 1'b0, 1'b0, -1);
    run_frame(511, 300, 6, -1, 1'b0, 1'b0, 300);
    run_frame(int'($urandom_range(511, 1)), 20, 4, 10, 1'b1, 1'b0, -1);
    run_frame(int'($urandom_range(511, 1)), 0, 0, -1, 1'b0, 1'b1, -1);

    // Reset in the middle of the vector phase
    load_frame(5, 20, 3, -1, 1'b0, -1);
    issue_start(5, 20, 3, c0);
    t = 0;
    while (n_valid < 5 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("reached_vec", int'(n_valid >= 5), 1);
    #2 rst_n = 1'b0;
    #1 chk("midframe_reset_outputs",
           int'({tx_valid, tx_val, tx_ipv, s_ready, busy, done, err}), 0);
    exp_q.delete();
    up_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    run_frame(1, 1, 1, -1, 1'b0, 1'b0, -1);

    for (int i = 0; i < 6; i++) begin
      run_frame(int'($urandom_range(511, 1)), int'($urandom_range(40, 0)),
                int'($urandom_range(25, 0)), -1, 1'b0, 1'b0, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/smvm_frame_tx.md
# smvm_frame_tx

Frame transmitter for the SMVM accelerator input port. It drives the accelerator's serial byte interface (`in_valid` / `val_in` / `ipv_in`) from a host-side command plus a ready/valid word stream. It buffers the stream in a small FIFO so that a frame, once started, is emitted without gaps. It pads the nonzero list to a multiple of the ALU lane count and enforces the inter-frame recovery gap the accelerator needs.

## Interface
- `K`, 4: nonzeros per ALU batch; the nonzero count is padded to a multiple of K.
- `DEPTH`, 8: FIFO depth in words, power of two, ≥2.
- `GAP`, 7: idle cycles forced after each frame; ≥ accelerator stall + reset cycles.
- `NNZ_W`, 12: width of the nonzero count.
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: frame request, sampled only in IDLE.
- `rows` in 9: matrix row count, 1..511.
- `cols` in 9: vector length, 0..511.
- `nnz` in NNZ_W: nonzero count before padding.
- `busy` out 1: high from the accepted start until the last GAP cycle.
- `done` out 1: one-cycle pulse at normal frame end.
- `err` out 1: one-cycle pulse on underrun abort.
- `s_valid` in 1: upstream word valid.
- `s_ready` out 1: upstream word accepted when `s_valid && s_ready`.
- `s_data` in 18: word layout is [7:0] value, [16:8] column index, [17] row_last.
- `tx_valid` out 1: drives accelerator `in_valid`.
- `tx_val` out 8: drives `val_in`.
- `tx_ipv` out 1: drives `ipv_in`.

## Operation
- Upstream word order: `cols` vector words first, using only [7:0]. Then `nnz` nonzero words.
- Total words W = cols + nnz. Pad count P = (K − nnz mod K) mod K.
- 9-bit fields go out as `tx_val` = field[8:1], `tx_ipv` = field[0].
- FSM states and transitions:
  - IDLE: `start` latches rows, cols, nnz and computes P. Go to PREFILL.
  - PREFILL: wait until FIFO count ≥ min(DEPTH, W), then go to HDR_R.
  - HDR_R: emit rows. Go to HDR_C.
  - HDR_C: emit cols. Go to VEC if cols>0, else NZ_V if nnz>0, else GAP.
  - VEC: pop one word per cycle and emit `tx_val`=value, `tx_ipv`=0. After `cols` pops go to NZ_V, or GAP if nnz=0.
  - NZ_V: emit value with `tx_ipv`=row_last. Do not pop. Go to NZ_I.
  - NZ_I: emit the column index in split form, then pop. After `nnz` nonzeros go to PD_V if P>0, else GAP.
  - PD_V / PD_I: emit value 0 / ipv 0, then index 0. Repeat P times, then go to GAP.
  - GAP: `tx_valid`=0 for GAP cycles, then go to IDLE.
- `s_ready` = busy && FIFO not full && accepted count < W, and is 0 in GAP.
- Words beyond W are never accepted.
- Underrun:
  - Trigger: in VEC or NZ_V with the FIFO empty.
  - Effect: `tx_valid` drops that cycle, `err` pulses, the FIFO and counters are cleared, and the FSM goes to GAP.
  - No `done` pulse. The host must resynchronise upstream.
  - NZ_I never underruns, because its word was already present in NZ_V.
- `start` while busy is ignored and the latched parameters are unchanged.
- Simultaneous FIFO push and pop keep the count unchanged. A push into a full FIFO cannot occur.

## Timing
- Reset values: `tx_valid`=0, `tx_val`=0, `tx_ipv`=0, `s_ready`=0, `busy`=0, `done`=0, `err`=0. FIFO is empty and the FSM is in IDLE.
- Reset mid-frame forces all outputs to these values immediately (asynchronous).
- All outputs are registered.
- `busy` rises the cycle after `start` is sampled.
- The first `tx_valid` comes one cycle after the PREFILL condition is met. With upstream always valid, the frame starts at cycle 2 + min(DEPTH, W) after start (start = cycle 0).
- A normal frame holds `tx_valid` contiguous for exactly 2 + cols + 2·(nnz+P) cycles.
- `done` pulses in the first GAP cycle.
- `busy` falls after GAP cycles; the next `start` can be sampled in that same cycle.

## Test plan
- rows=3, cols=4, nnz=4, upstream always valid → 14 contiguous `tx_valid` cycles. Header is (0x01,1) then (0x02,0). Next come 4 vector bytes, then 4 (val,row_last)/(col split) pairs. `done` pulses once; `busy` low 7 cycles later.
- nnz=5 (K=4), cols=2 → P=3. Three trailing pairs are (0x00,0)/(0x00,0). `tx_valid` length = 2+2+16 = 20.
- cols=300, rows=511 → header bytes (0xFF,1), (0x96,0). A column index of 300 in a nonzero emits (0x96,0).
- cols=20, DEPTH=8, `s_valid` deasserted for 30 cycles after 10 vector words → `tx_valid` drops in the underrun cycle, `err` pulses once with no `done`. `s_ready`=0 during GAP; back in IDLE after 7 cycles.
- cols=0, nnz=0 → only 2 header cycles, then GAP and `done`. A `start` pulse during busy produces no second frame.
- `rst_n` asserted mid-VEC → all outputs 0 immediately. After release, a fresh frame (rows=1, cols=1, nnz=1) completes correctly in 2+1+8 = 11 cycles.
